// File: rtl/mux_alloc_pkg.sv
// Shared definitions for the packet-lock mux allocator.
// Holds the flit type codes, the select width (`PORT+1 bits) and the
// allocator FSM state encoding, plus small flit classification helpers.
// No ports (package).
`ifndef MUX_ALLOC_DEFS_SV
`define MUX_ALLOC_DEFS_SV
`define TYPE_NONE 2'b00
`define TYPE_HEAD 2'b01
`define TYPE_DATA 2'b10
`define TYPE_TAIL 2'b11
`define PORT 1
`endif

package mux_alloc_pkg;

  // State codes equal the select pattern of the locked port.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_e;

  function automatic logic is_head(input logic [1:0] t);
    return t == `TYPE_HEAD;
  endfunction

  function automatic logic is_tail(input logic [1:0] t);
    return t == `TYPE_TAIL;
  endfunction

endpackage

// File: rtl/mux_alloc_rr_arb2.sv
// Two-request round-robin arbiter with its pointer register.
// Ports:
//   clk    - clock, rising edge
//   rst_   - asynchronous active-low reset (pointer favours request 0)
//   req_i  - request vector, bit k = requester k
//   gnt_o  - one-hot grant (combinational), all-zero when no request
// Every grant issued is taken the same edge, so the pointer moves to favour
// the requester that did not win.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;   // 0: favour request 0, 1: favour request 1
  logic ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // Winner 0 -> favour 1 next; winner 1 -> favour 0 next.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o != 2'b00) ptr_d = gnt_o[0];
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_alloc.sv
// Packet-lock mux allocator for two input ports sharing one output.
// A head flit requests the output; the granted port keeps the lock until
// its tail handshakes, then the lock passes directly to a waiting head on
// the other port or returns to idle.
// Ports:
//   clk, rst_            - clock / asynchronous active-low reset
//   ivalid_k, itype_k    - flit presented by port k and its type code
//   oready               - downstream accepts a flit this cycle
//   iready_k             - port k flit consumed this cycle
//   sel                  - one-hot mux select (01 port0, 10 port1, 0 none)
//   busy                 - a packet lock is held
//   pkt_cnt_0/1          - saturating granted-packet counters, present only
//                          when ALLOC_STATS_EN is defined
module mux_alloc
  import mux_alloc_pkg::*;
#(
  parameter int ALLOC_PORTS = 2
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           ivalid_0,
  input  logic [1:0]     itype_0,
  input  logic           ivalid_1,
  input  logic [1:0]     itype_1,
  input  logic           oready,
  output logic           iready_0,
  output logic           iready_1,
  output logic [`PORT:0] sel,
  output logic           busy
`ifdef ALLOC_STATS_EN
  ,
  output logic [15:0]    pkt_cnt_0,
  output logic [15:0]    pkt_cnt_1
`endif
);

  state_e                 state_q;
  logic [`PORT:0]         sel_q;
  logic                   busy_q;
  logic [ALLOC_PORTS-1:0] head;
  logic [ALLOC_PORTS-1:0] req;
  logic [ALLOC_PORTS-1:0] gnt;
  logic                   tail_hs;

  assign head = {ivalid_1 && is_head(itype_1), ivalid_0 && is_head(itype_0)};

  // Only the locked port is ever consumed; heads are consumed inside LOCKk.
  assign iready_0 = (state_q == LOCK0) && ivalid_0 && oready;
  assign iready_1 = (state_q == LOCK1) && ivalid_1 && oready;
  assign tail_hs  = (iready_0 && is_tail(itype_0)) ||
                    (iready_1 && is_tail(itype_1));

  // While locked, only the other port may request, and only on the tail
  // handshake; a head on the locked port is plain payload.
  always_comb begin
    req = '0;
    case (state_q)
      IDLE:    req = head;
      LOCK0:   if (tail_hs) req = {head[1], 1'b0};
      LOCK1:   if (tail_hs) req = {1'b0, head[0]};
      default: req = '0;
    endcase
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_  (rst_),
    .req_i (req),
    .gnt_o (gnt)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else if (gnt[0]) begin
      state_q <= LOCK0;
      sel_q   <= 2'b01;
      busy_q  <= 1'b1;
    end else if (gnt[1]) begin
      state_q <= LOCK1;
      sel_q   <= 2'b10;
      busy_q  <= 1'b1;
    end else if (tail_hs) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
    end
  end

  assign sel  = sel_q;
  assign busy = busy_q;

`ifdef ALLOC_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt0_q <= 16'h0000;
      cnt1_q <= 16'h0000;
    end else begin
      if (gnt[0] && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
      if (gnt[1] && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign pkt_cnt_0 = cnt0_q;
  assign pkt_cnt_1 = cnt1_q;
`endif

endmodule
